systolic_sched: RTL and testbench
=================================

SYSTOLIC_SCHED -- requirements
Module: systolic_sched

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand/result element width in bits.
REQ-002 SHALL have parameter N, default 3, meaning systolic array dimension (NxN).
REQ-003 SHALL have i_clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have i_req_valid  input  2  per-requester job valid.
REQ-006 SHALL have o_req_ready  output  2  per-requester job accept, one-hot or zero.
REQ-007 SHALL have i_req_mode  input  2  per-requester array mode bit.
REQ-008 SHALL have i_req_A, i_req_B  input  2*W*N*N each  per-requester operand matrices; requester i occupies slice i; element (r,k) at index k*N+r.
REQ-009 SHALL have o_arr_en, o_arr_mode, o_arr_sync  output  1 each  array enable, mode, end-of-job sync.
REQ-010 SHALL have o_arr_A, o_arr_B  output  W*N each  skewed array lane inputs, lane r at slice r.
REQ-011 SHALL have i_arr_C  input  W*N*N  array result matrix.
REQ-012 SHALL have o_resp_valid  output  1, o_resp_id  output  1, o_resp_C  output  W*N*N, i_resp_ready  input  1  result handshake.
REQ-013 SHALL have o_busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> FEED -> DRAIN -> SYNC -> CAPT -> RESP -> IDLE.
REQ-015 In IDLE, o_req_ready SHALL be combinational grant: one requester only, only if its i_req_valid is high; acceptance = valid & ready in IDLE.
REQ-016 Arbitration SHALL be round-robin: if both valid, grant the requester not granted last; pointer updates on acceptance only; after reset requester 0 wins a tie.
REQ-017 On acceptance SHALL latch granted A, B, mode and id, and enter FEED next cycle; o_req_ready SHALL be 0 in all other states.
REQ-018 FEED SHALL last exactly N cycles, counter k=0..N-1; pre-skew lane r of A = A(r,k), lane j of B = B(k,j); pre-skew lanes SHALL be 0 outside FEED.
REQ-019 o_arr_A/o_arr_B lane r SHALL equal pre-skew lane r delayed r cycles (lane 0 undelayed).
REQ-020 DRAIN SHALL last exactly 2N-1 cycles; SYNC exactly 1 cycle with o_arr_sync=1; CAPT exactly 1 cycle.
REQ-021 o_arr_en SHALL be 1 in FEED, DRAIN, SYNC; o_arr_mode SHALL hold latched mode from FEED through SYNC, 0 otherwise.
REQ-022 o_resp_C SHALL register i_arr_C at the clock edge ending CAPT; o_resp_id set at the same edge; o_resp_valid=1 throughout RESP.
REQ-023 For N=3, job accepted in cycle T: FEED T+1..T+3, DRAIN T+4..T+8, SYNC T+9, CAPT T+10, o_resp_valid first high T+11.
REQ-024 RESP SHALL hold o_resp_valid, o_resp_C, o_resp_id stable until i_resp_ready; exit to IDLE on the handshake edge; new acceptance possible the next cycle.
REQ-025 Requester valid changes during non-IDLE states SHALL be ignored; no queuing.
REQ-026 Counters SHALL be $clog2(2N)-bit minimum, reset to 0 on every state entry; no wrap beyond stated lengths.

Reset
REQ-027 i_rst_n low SHALL immediately force IDLE, RR pointer to requester 0, counters, skew registers, latched operands and all outputs to 0.
REQ-028 Reset mid-job SHALL abandon the job with no response; first acceptance permitted on the first edge after deassertion.

Structure
REQ-029 State encoding enum and the derived constants FEED_LEN=N, DRAIN_LEN=2N-1 SHALL live in shared package systolic_pkg.
REQ-030 Skew SHALL use one sub-module skew_line (param WIDTH, DEPTH; DEPTH=0 passthrough; async active-low reset), one instance per delayed lane.

Verification
REQ-031 Req0 only, A=identity, B=[1..9], mode 0 -> o_req_ready[0] at T, o_arr_sync at T+9, o_resp_valid at T+11, id 0, o_resp_C = model C.
REQ-032 Both valid at reset-exit, then both again -> grants 0 then 1; responses id 0 then id 1.
REQ-033 i_resp_ready low 20 cycles in RESP -> outputs stable, o_busy=1, o_req_ready=0, no new grant.
REQ-034 A all 5, B all 7: check o_arr_A lane 2 = 5 only in T+3..T+5, 0 elsewhere.
REQ-035 i_rst_n low at T+2 (FEED) -> all outputs 0 immediately; no o_resp_valid; next job completes normally.
REQ-036 Handshake in RESP at cycle R with req1 valid -> o_req_ready[1] at R+1, second result valid at R+12.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared FSM state encoding and job-phase length helpers for the systolic array scheduler.
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN,
        ST_SYNC,
        ST_CAPT,
        ST_RESP
    } state_e;

    function automatic int feed_len(input int n);
        return n;
    endfunction

    // Last operand pair enters the far corner PE 2N-2 cycles after FEED ends, plus one to accumulate.
    function automatic int drain_len(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int cnt_width(input int n);
        return (2 * n > 2) ? $clog2(2 * n) : 1;
    endfunction

    localparam int N_DEF     = 3;
    localparam int FEED_LEN  = feed_len(N_DEF);
    localparam int DRAIN_LEN = drain_len(N_DEF);

endpackage

// File: rtl/skew_line.sv
// Fixed-depth delay line used to diagonally skew one array lane; DEPTH=0 is a wire.
module skew_line #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_q = i_d;
        end else begin : g_delay
            logic [WIDTH-1:0] r_sh [DEPTH];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_sh[i] <= '0;
                    end
                end else begin
                    r_sh[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_sh[i] <= r_sh[i-1];
                    end
                end
            end

            assign o_q = r_sh[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_sched.sv
// Two-requester job scheduler for an NxN output-stationary systolic array:
// round-robin accept, skewed operand feed, drain, sync, result capture and response handshake.
module systolic_sched
    import systolic_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [1:0]           i_req_valid,
    output logic [1:0]           o_req_ready,
    input  logic [1:0]           i_req_mode,
    input  logic [2*W*N*N-1:0]   i_req_A,
    input  logic [2*W*N*N-1:0]   i_req_B,
    output logic                 o_arr_en,
    output logic                 o_arr_mode,
    output logic                 o_arr_sync,
    output logic [W*N-1:0]       o_arr_A,
    output logic [W*N-1:0]       o_arr_B,
    input  logic [W*N*N-1:0]     i_arr_C,
    output logic                 o_resp_valid,
    output logic                 o_resp_id,
    output logic [W*N*N-1:0]     o_resp_C,
    input  logic                 i_resp_ready,
    output logic                 o_busy
);

    localparam int MW      = W * N * N;
    localparam int LW      = W * N;
    localparam int C_FEED  = feed_len(N);
    localparam int C_DRAIN = drain_len(N);
    localparam int CW      = cnt_width(N);

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_prio;
    logic             r_id;
    logic [MW-1:0]    r_A;
    logic [MW-1:0]    r_B;
    logic             r_arr_en;
    logic             r_arr_mode;
    logic             r_arr_sync;
    logic             r_busy;
    logic             r_resp_valid;
    logic             r_resp_id;
    logic [MW-1:0]    r_resp_C;

    logic [1:0]       w_gnt;
    logic             w_accept;
    logic             w_gnt_id;
    logic [LW-1:0]    w_pre_A;
    logic [LW-1:0]    w_pre_B;

    // Grant is gated by reset so no requester sees ready while the block is held in reset.
    always_comb begin
        w_gnt = 2'b00;
        if (i_rst_n && (r_state == ST_IDLE)) begin
            if (i_req_valid == 2'b11) begin
                w_gnt = r_prio ? 2'b10 : 2'b01;
            end else begin
                w_gnt = i_req_valid;
            end
        end
    end

    assign w_accept    = |w_gnt;
    assign w_gnt_id    = w_gnt[1];
    assign o_req_ready = w_gnt;

    // Unskewed lanes: column k of A and row k of B while feeding, zero otherwise.
    always_comb begin
        w_pre_A = '0;
        w_pre_B = '0;
        if (r_state == ST_FEED) begin
            for (int r = 0; r < N; r++) begin
                w_pre_A[r*W +: W] = r_A[(int'(r_cnt) * N + r) * W +: W];
                w_pre_B[r*W +: W] = r_B[(r * N + int'(r_cnt)) * W +: W];
            end
        end
    end

    assign o_arr_A[W-1:0] = w_pre_A[W-1:0];
    assign o_arr_B[W-1:0] = w_pre_B[W-1:0];

    generate
        for (genvar r = 1; r < N; r++) begin : g_lane
            skew_line #(
                .WIDTH (W),
                .DEPTH (r)
            ) u_skew_a (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_d     (w_pre_A[r*W +: W]),
                .o_q     (o_arr_A[r*W +: W])
            );

            skew_line #(
                .WIDTH (W),
                .DEPTH (r)
            ) u_skew_b (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_d     (w_pre_B[r*W +: W]),
                .o_q     (o_arr_B[r*W +: W])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_prio       <= 1'b0;
            r_id         <= 1'b0;
            r_A          <= '0;
            r_B          <= '0;
            r_arr_en     <= 1'b0;
            r_arr_mode   <= 1'b0;
            r_arr_sync   <= 1'b0;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_C     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_A        <= w_gnt_id ? i_req_A[MW +: MW] : i_req_A[0 +: MW];
                        r_B        <= w_gnt_id ? i_req_B[MW +: MW] : i_req_B[0 +: MW];
                        r_id       <= w_gnt_id;
                        r_prio     <= ~w_gnt_id;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_arr_en   <= 1'b1;
                        r_arr_mode <= i_req_mode[w_gnt_id];
                        r_state    <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (r_cnt == CW'(C_FEED - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == CW'(C_DRAIN - 1)) begin
                        r_cnt      <= '0;
                        r_arr_sync <= 1'b1;
                        r_state    <= ST_SYNC;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SYNC: begin
                    r_arr_en   <= 1'b0;
                    r_arr_mode <= 1'b0;
                    r_arr_sync <= 1'b0;
                    r_cnt      <= '0;
                    r_state    <= ST_CAPT;
                end
                ST_CAPT: begin
                    r_resp_C     <= i_arr_C;
                    r_resp_id    <= r_id;
                    r_resp_valid <= 1'b1;
                    r_cnt        <= '0;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_arr_en     = r_arr_en;
    assign o_arr_mode   = r_arr_mode;
    assign o_arr_sync   = r_arr_sync;
    assign o_busy       = r_busy;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_id    = r_resp_id;
    assign o_resp_C     = r_resp_C;

endmodule

// File: tb/tb_systolic_sched.sv
// Scoreboard bench: a behavioural NxN array drives i_arr_C, a cycle model predicts grants and lane streams.
module tb_systolic_sched;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int MW = W * N * N;
    localparam int LW = W * N;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [1:0]        req_mode = '0;
    logic [2*MW-1:0]   req_A = '0;
    logic [2*MW-1:0]   req_B = '0;
    logic              arr_en, arr_mode, arr_sync;
    logic [LW-1:0]     arr_A, arr_B;
    logic [MW-1:0]     arr_C = '0;
    logic              resp_valid, resp_id;
    logic [MW-1:0]     resp_C;
    logic              resp_ready = 1'b1;
    logic              busy;

    systolic_sched #(.W(W), .N(N)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_mode   (req_mode),
        .i_req_A      (req_A),
        .i_req_B      (req_B),
        .o_arr_en     (arr_en),
        .o_arr_mode   (arr_mode),
        .o_arr_sync   (arr_sync),
        .o_arr_A      (arr_A),
        .o_arr_B      (arr_B),
        .i_arr_C      (arr_C),
        .o_resp_valid (resp_valid),
        .o_resp_id    (resp_id),
        .o_resp_C     (resp_C),
        .i_resp_ready (resp_ready),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          id;
        logic [MW-1:0] c;
        int            t;
    } exp_t;

    exp_t          sb_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    bit            m_idle  = 1'b1;
    bit            m_pend  = 1'b0;
    bit            m_prio  = 1'b0;
    bit            job_act = 1'b0;
    int            job_T   = 0;
    logic [MW-1:0] job_A, job_B;
    logic          job_mode;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [W-1:0] el(input logic [MW-1:0] m, input int r, input int c);
        return m[(c * N + r) * W +: W];
    endfunction

    // Array contract used by this bench: mode 0 -> C = A*B, mode 1 -> C = A*B + 1 elementwise.
    function automatic logic [MW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic mode);
        logic [MW-1:0] c;
        logic [W-1:0]  s;
        c = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = W'(mode);
                for (int k = 0; k < N; k++) s = s + el(a, i, k) * el(b, k, j);
                c[(j * N + i) * W +: W] = s;
            end
        end
        return c;
    endfunction

    function automatic logic [LW-1:0] exp_lane(input bit is_b, input int c);
        logic [LW-1:0] v;
        int d;
        v = '0;
        for (int l = 0; l < N; l++) begin
            d = c - job_T - 1 - l;
            if (job_act && d >= 0 && d < N) v[l*W +: W] = is_b ? el(job_B, d, l) : el(job_A, l, d);
        end
        return v;
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int e = 0; e < N * N; e++) m[e*W +: W] = W'($urandom_range(0, 255));
        return m;
    endfunction

    // Behavioural output-stationary array: A moves right, B moves down, one hop per cycle.
    logic [W-1:0] pa [N][N];
    logic [W-1:0] pb [N][N];
    logic [W-1:0] acc[N][N];

    always @(negedge clk) begin
        logic [W-1:0] ain, bin;
        logic [MW-1:0] cm;
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pa[i][j] = '0; pb[i][j] = '0; acc[i][j] = '0;
                end
        end else begin
            if (arr_en) begin
                for (int i = N - 1; i >= 0; i--)
                    for (int j = N - 1; j >= 0; j--) begin
                        ain = (j == 0) ? arr_A[i*W +: W] : pa[i][j-1];
                        bin = (i == 0) ? arr_B[j*W +: W] : pb[i-1][j];
                        acc[i][j] = acc[i][j] + ain * bin;
                        pa[i][j] = ain;
                        pb[i][j] = bin;
                    end
            end
            if (arr_sync) begin
                cm = '0;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        cm[(j * N + i) * W +: W] = acc[i][j] + W'(arr_mode);
                        pa[i][j] = '0; pb[i][j] = '0; acc[i][j] = '0;
                    end
                arr_C = cm;
            end
        end
    end

    // Monitor: predicts every observable output each cycle and scores responses from the queue.
    always @(negedge clk) begin
        logic [1:0] eg;
        bit         in_job, ev;
        if (!rst_n) begin
            chk("reset_outputs", 512'({req_ready, arr_en, arr_mode, arr_sync, arr_A, arr_B,
                                       resp_valid, resp_id, resp_C, busy}), 512'(0));
            m_idle = 1'b1; m_pend = 1'b0; m_prio = 1'b0; job_act = 1'b0;
            sb_q.delete();
        end else begin
            if (m_pend) begin m_idle = 1'b1; m_pend = 1'b0; end
            eg = 2'b00;
            if (m_idle) begin
                if (req_valid == 2'b11) eg = m_prio ? 2'b10 : 2'b01;
                else eg = req_valid;
            end
            chk("req_ready", 512'(req_ready), 512'(eg));
            chk("busy", 512'(busy), 512'(!m_idle));
            in_job = job_act && cyc >= job_T + 1 && cyc <= job_T + 3 * N;
            chk("arr_en", 512'(arr_en), 512'(in_job));
            chk("arr_mode", 512'(arr_mode), 512'(in_job ? job_mode : 1'b0));
            chk("arr_sync", 512'(arr_sync), 512'(job_act && cyc == job_T + 3 * N));
            chk("arr_A", 512'(arr_A), 512'(exp_lane(1'b0, cyc)));
            chk("arr_B", 512'(arr_B), 512'(exp_lane(1'b1, cyc)));
            ev = (sb_q.size() > 0) && (cyc >= sb_q[0].t);
            chk("resp_valid", 512'(resp_valid), 512'(ev));
            if (ev) begin
                chk("resp_id", 512'(resp_id), 512'(sb_q[0].id));
                chk("resp_C", 512'(resp_C), 512'(sb_q[0].c));
                if (resp_ready) begin
                    void'(sb_q.pop_front());
                    m_pend = 1'b1;
                end
            end
            if (eg != 2'b00) begin
                job_act  = 1'b1;
                job_T    = cyc;
                job_A    = req_A[eg[1] * MW +: MW];
                job_B    = req_B[eg[1] * MW +: MW];
                job_mode = req_mode[eg[1]];
                sb_q.push_back('{id: eg[1], c: matmul(job_A, job_B, job_mode), t: cyc + 3 * N + 2});
                m_idle = 1'b0;
                m_prio = ~eg[1];
            end
        end
    end

    task automatic set_job(input int i, input logic [MW-1:0] a, input logic [MW-1:0] b, input logic mode);
        req_A[i*MW +: MW] = a;
        req_B[i*MW +: MW] = b;
        req_mode[i]       = mode;
        req_valid[i]      = 1'b1;
    endtask

    task automatic wait_accept(input int i);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready[i] && req_valid[i]) break;
        end
        chk($sformatf("accept_req%0d_timeout", i), 512'(k >= 200), 512'(0));
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!busy && sb_q.size() == 0 && req_valid == 2'b00) break;
        end
        chk("idle_timeout", 512'(k >= 400), 512'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MW-1:0] ma, mb;
        logic [1:0]    acc_s;

        // Both requesters valid while reset releases: requester 0 first, then 1.
        set_job(0, rand_mat(), rand_mat(), 1'b0);
        set_job(1, rand_mat(), rand_mat(), 1'b1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_accept(0);
        wait_accept(1);
        wait_idle();

        // Identity times 1..9 from requester 0.
        for (int e = 0; e < N * N; e++) begin
            ma[e*W +: W] = ((e % N) == (e / N)) ? W'(1) : W'(0);
            mb[e*W +: W] = W'(e + 1);
        end
        set_job(0, ma, mb, 1'b0);
        wait_accept(0);
        wait_idle();

        // Uniform operands make the skew window of each lane easy to see.
        for (int e = 0; e < N * N; e++) begin
            ma[e*W +: W] = W'(5);
            mb[e*W +: W] = W'(7);
        end
        set_job(1, ma, mb, 1'b1);
        wait_accept(1);
        wait_idle();

        // Response held off 20 cycles with requester 0 waiting; grant must follow the handshake.
        resp_ready = 1'b0;
        set_job(1, rand_mat(), rand_mat(), 1'b0);
        wait_accept(1);
        set_job(0, rand_mat(), rand_mat(), 1'b1);
        for (int k = 0; k < 200 && !resp_valid; k++) @(negedge clk);
        repeat (20) @(posedge clk);
        #1 resp_ready = 1'b1;
        wait_accept(0);
        // Requester 1 queued during the job is granted the cycle after the handshake.
        set_job(1, rand_mat(), rand_mat(), 1'b0);
        wait_accept(1);
        wait_idle();

        // Reset in the second FEED cycle abandons the job.
        set_job(0, rand_mat(), rand_mat(), 1'b0);
        wait_accept(0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("reset_immediate", 512'({req_ready, arr_en, arr_mode, arr_sync, arr_A, arr_B,
                                        resp_valid, resp_id, resp_C, busy}), 512'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        set_job(1, rand_mat(), rand_mat(), 1'b1);
        wait_accept(1);
        wait_idle();

        // Random traffic with random response back-pressure.
        for (int c = 0; c < 900; c++) begin
            @(negedge clk);
            acc_s = req_ready & req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (acc_s[i]) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(0, 3) == 0)
                    set_job(i, rand_mat(), rand_mat(), 1'($urandom_range(0, 1)));
            end
            resp_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        acc_s = req_ready & req_valid;
        @(posedge clk);
        #1 resp_ready = 1'b1;
        req_valid = req_valid & ~acc_s;
        for (int i = 0; i < 2; i++) if (req_valid[i]) wait_accept(i);
        wait_idle();
        chk("scoreboard_empty", 512'(sb_q.size()), 512'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
